// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test sweeper.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_ZERO     = 2;
  localparam int unsigned FLAG_NEGATIVE = 3;
  localparam int unsigned FLAG_PARITY   = 4;
  localparam int unsigned FLAG_MODULO   = 5;
  localparam int unsigned FLAG_SIGN     = 6;
  localparam int unsigned FLAG_W        = FLAG_SIGN + 1;

endpackage

// File: rtl/alu_misr.sv
// Multiple-input signature register: folds a wide response word into SIG_W bits
// and shifts it through a Galois LFSR.
module alu_misr
  import alu_bist_pkg::*;
#(
  parameter int unsigned DATA_W = 39,
  parameter int unsigned SIG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_next_c
);

  localparam int unsigned NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W  = NCHUNK * SIG_W;

  logic [PAD_W-1:0] data_pad;
  logic [SIG_W-1:0] fold_c;
  logic [SIG_W-1:0] shifted_c;
  logic [SIG_W-1:0] sig_q, sig_d;

  // Zero-pad, XOR-fold the chunks, then shift with feedback; clear has priority.
  always_comb begin
    data_pad = PAD_W'(data);
    fold_c   = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      fold_c = fold_c ^ data_pad[i*SIG_W +: SIG_W];
    end
    shifted_c  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_W'(MISR_POLY) : '0);
    sig_next_c = shifted_c ^ fold_c;
    sig_d      = sig_q;
    if (clear) begin
      sig_d = SIG_W'(MISR_SEED);
    end else if (enable) begin
      sig_d = sig_next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SIG_W'(MISR_SEED);
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_bist_sweeper.sv
// Sweeps (a, b, sel) vectors into a combinational ALU and compacts every
// response into a MISR signature checked against a golden value.
module alu_bist_sweeper
  import alu_bist_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned NUM_OPS = 35,
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned SIG_W   = 32,
  parameter int unsigned CNT_W   = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N-1:0]      a_limit,
  input  logic [N-1:0]      b_limit,
  input  logic [SIG_W-1:0]  golden_sig,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [N-1:0]      alu_result,
  input  logic [N-1:0]      alu_upper,
  input  logic [6:0]        alu_flags,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int unsigned      DATA_W   = 2 * N + FLAG_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OPS - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d, b_q, b_d;
  logic [N-1:0]      a_lim_q, a_lim_d, b_lim_q, b_lim_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              cap_q, cap_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              misr_clear, last_vec, go;
  logic [SIG_W-1:0]  misr_sig, misr_next;

  // Next-state, operand counters and capture pipeline.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    a_lim_d    = a_lim_q;
    b_lim_d    = b_lim_q;
    cap_d      = 1'b0;
    resp_d     = {alu_flags, alu_upper, alu_result};
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    misr_clear = 1'b0;
    last_vec   = (a_q == a_lim_q) && (b_q == b_lim_q) && (sel_q == SEL_LAST);
    go         = start && !abort;

    if (cap_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d    = RUN;
          a_d        = '0;
          b_d        = '0;
          sel_d      = '0;
          a_lim_d    = a_limit;
          b_lim_d    = b_limit;
          cnt_d      = '0;
          misr_clear = 1'b1;
        end
      end
      RUN: begin
        cap_d = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (last_vec) begin
          state_d = DRAIN;
        end else if (sel_q == SEL_LAST) begin
          sel_d = '0;
          if (b_q == b_lim_q) begin
            b_d = '0;
            a_d = a_q + N'(1);
          end else begin
            b_d = b_q + N'(1);
          end
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          pass_d  = ((cap_q ? misr_next : misr_sig) == golden_sig);
        end
      end
      default: ;
    endcase

    if (state_d != DONE) begin
      pass_d = 1'b0;
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      a_lim_q <= '0;
      b_lim_q <= '0;
      cap_q   <= 1'b0;
      resp_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      a_lim_q <= a_lim_d;
      b_lim_q <= b_lim_d;
      cap_q   <= cap_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  alu_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .clear      (misr_clear),
    .enable     (cap_q),
    .data       (resp_q),
    .sig        (misr_sig),
    .sig_next_c (misr_next)
  );

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_sig;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_alu_bist_sweeper.sv
// Bench for alu_bist_sweeper: a zero-returning stub instance driven from a
// vector table, and a full instance driven by a reference ALU model.
module tb_alu_bist_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Full instance driven by a reference ALU
  logic        start_m, abort_m;
  logic [15:0] a_lim_m, b_lim_m;
  logic [31:0] golden_m;
  logic [15:0] m_a, m_b, m_result, m_upper;
  logic [5:0]  m_sel;
  logic [6:0]  m_flags;
  logic        m_busy, m_done, m_pass;
  logic [31:0] m_sig;
  logic [39:0] m_cnt;

  // Stub instance: one op, ALU returns zero
  logic        start_s, abort_s;
  logic [15:0] a_lim_s, b_lim_s;
  logic [31:0] golden_s;
  logic [15:0] s_a, s_b;
  logic [5:0]  s_sel;
  logic        s_busy, s_done, s_pass;
  logic [31:0] s_sig;
  logic [39:0] s_cnt;

  alu_bist_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start_m), .abort(abort_m),
    .a_limit(a_lim_m), .b_limit(b_lim_m), .golden_sig(golden_m),
    .alu_a(m_a), .alu_b(m_b), .alu_sel(m_sel),
    .alu_result(m_result), .alu_upper(m_upper), .alu_flags(m_flags),
    .busy(m_busy), .done(m_done), .pass(m_pass),
    .signature(m_sig), .vec_count(m_cnt)
  );

  alu_bist_sweeper #(.NUM_OPS(1)) u_stub (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
    .a_limit(a_lim_s), .b_limit(b_lim_s), .golden_sig(golden_s),
    .alu_a(s_a), .alu_b(s_b), .alu_sel(s_sel),
    .alu_result(16'h0000), .alu_upper(16'h0000), .alu_flags(7'h00),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .signature(s_sig), .vec_count(s_cnt)
  );

  function automatic logic [38:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] sel);
    logic [16:0] s;
    logic [15:0] r, u;
    logic [6:0]  f;
    s = {1'b0, a} + {1'b0, b} + 17'(sel);
    r = s[15:0];
    u = (a ^ {b[7:0], b[15:8]}) + 16'(sel) * 16'h0101;
    f = {r[15], sel[0], ^r, u[15], (r == 16'h0000), a[0] ^ b[0], s[16]};
    return {f, u, r};
  endfunction

  always_comb {m_flags, m_upper, m_result} = ref_alu(m_a, m_b, m_sel);

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [38:0] d);
    logic [63:0] w;
    logic [31:0] x;
    w = {25'd0, d};
    x = w[31:0] ^ w[63:32];
    if (s[31]) return ({s[30:0], 1'b0} ^ 32'h04C11DB7) ^ x;
    return {s[30:0], 1'b0} ^ x;
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] al;
    logic [15:0] bl;
    logic [31:0] gold;
    int          vecs;
    logic [31:0] sig;
    logic        pass;
  } stub_vec_t;

  stub_vec_t tbl[5];

  initial begin
    int          cyc;
    int          seq_err;
    logic [15:0] ea, eb;
    logic [5:0]  es;
    logic [31:0] exp_sig;

    tbl[0] = '{16'd0, 16'd0, 32'hFB3EE249, 1, 32'hFB3EE249, 1'b1};
    tbl[1] = '{16'd0, 16'd0, 32'hFB3EE248, 1, 32'hFB3EE249, 1'b0};
    tbl[2] = '{16'd1, 16'd0, 32'hF2BCD925, 2, 32'hF2BCD925, 1'b1};
    tbl[3] = '{16'd1, 16'd1, 32'hC7B0424D, 4, 32'hC7B0424D, 1'b1};
    tbl[4] = '{16'd2, 16'd1, 32'h13822FEC, 6, 32'h13822FED, 1'b0};

    rst = 1'b1;
    start_m = 1'b0; abort_m = 1'b0; a_lim_m = '0; b_lim_m = '0; golden_m = '0;
    start_s = 1'b0; abort_s = 1'b0; a_lim_s = '0; b_lim_s = '0; golden_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_a", m_a, 0);
    chk("rst_alu_b", m_b, 0);
    chk("rst_alu_sel", m_sel, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_pass", m_pass, 0);
    chk("rst_vec_count", m_cnt, 0);
    chk("rst_signature", m_sig, 32'hFFFFFFFF);
    rst = 1'b0;

    // Table-driven stub sweeps
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_lim_s = tbl[i].al; b_lim_s = tbl[i].bl; golden_s = tbl[i].gold; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      cyc = 1;
      chk($sformatf("stub%0d_busy_c1", i), s_busy, 1);
      chk($sformatf("stub%0d_done_c1", i), s_done, 0);
      while (!s_done && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("stub%0d_done_cycle", i), cyc, tbl[i].vecs + 2);
      chk($sformatf("stub%0d_busy_done", i), s_busy, 0);
      chk($sformatf("stub%0d_vec_count", i), s_cnt, tbl[i].vecs);
      chk($sformatf("stub%0d_signature", i), s_sig, tbl[i].sig);
      chk($sformatf("stub%0d_pass", i), s_pass, tbl[i].pass);
    end

    // Full 140-vector sweep against the reference model
    exp_sig = 32'hFFFFFFFF;
    for (int a = 0; a <= 1; a++)
      for (int b = 0; b <= 1; b++)
        for (int s = 0; s < 35; s++)
          exp_sig = misr_step(exp_sig, ref_alu(16'(a), 16'(b), 6'(s)));
    @(negedge clk);
    a_lim_m = 16'd1; b_lim_m = 16'd1; golden_m = exp_sig; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    seq_err = 0; ea = '0; eb = '0; es = '0;
    for (int k = 1; k <= 140; k++) begin
      if ({m_a, m_b, m_sel} !== {ea, eb, es} || m_busy !== 1'b1) seq_err++;
      if (k == 36) chk("vec36", {m_a, m_b, m_sel}, {16'd0, 16'd1, 6'd0});
      if (k == 140) chk("vec140", {m_a, m_b, m_sel}, {16'd1, 16'd1, 6'd34});
      es = es + 6'd1;
      if (es == 6'd35) begin
        es = '0;
        eb = eb + 16'd1;
        if (eb == 16'd2) begin
          eb = '0;
          ea = ea + 16'd1;
        end
      end
      @(negedge clk);
    end
    chk("operand_sequence", seq_err, 0);
    chk("drain_busy", m_busy, 1);
    chk("drain_done", m_done, 0);
    chk("drain_pass", m_pass, 0);
    @(negedge clk);
    chk("full_done", m_done, 1);
    chk("full_busy", m_busy, 0);
    chk("full_vec_count", m_cnt, 140);
    chk("full_signature", m_sig, exp_sig);
    chk("full_pass", m_pass, 1);

    // Restart, ignored start at cycle 5, abort at cycle 10
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    chk("restart_sel_c1", m_sel, 0);
    chk("restart_done_c1", m_done, 0);
    repeat (4) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    chk("start_ignored_sel", m_sel, 5);
    chk("start_ignored_busy", m_busy, 1);
    repeat (4) @(negedge clk);
    abort_m = 1'b1;
    @(negedge clk);
    abort_m = 1'b0;
    chk("abort_busy", m_busy, 0);
    chk("abort_done", m_done, 0);
    chk("abort_pass", m_pass, 0);
    chk("abort_vec_count", m_cnt, 9);
    chk("abort_sel_hold", m_sel, 9);
    repeat (3) @(negedge clk);
    chk("abort_count_frozen", m_cnt, 9);

    // Start and abort together: abort wins
    start_m = 1'b1; abort_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0; abort_m = 1'b0;
    chk("start_abort_busy", m_busy, 0);
    chk("start_abort_count", m_cnt, 9);
    chk("start_abort_sel", m_sel, 9);

    // Fresh start after abort
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    chk("resweep_vec", {m_a, m_b, m_sel}, 38'd0);
    chk("resweep_sig", m_sig, 32'hFFFFFFFF);
    chk("resweep_count", m_cnt, 0);
    chk("resweep_busy", m_busy, 1);

    // Reset mid-sweep at cycle 80, vector (1,0,9)
    repeat (79) @(negedge clk);
    chk("mid_vec80", {m_a, m_b, m_sel}, {16'd1, 16'd0, 6'd9});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_vec", {m_a, m_b, m_sel}, 38'd0);
    chk("midrst_busy", m_busy, 0);
    chk("midrst_done", m_done, 0);
    chk("midrst_pass", m_pass, 0);
    chk("midrst_count", m_cnt, 0);
    chk("midrst_sig", m_sig, 32'hFFFFFFFF);
    @(negedge clk);
    chk("midrst_stays_idle", m_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
